// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, ALU functions, branch conditions,
// register ids and the condition-code record with its branch evaluator.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] ALUADD = 4'h0;
  localparam logic [3:0] ALUSUB = 4'h1;
  localparam logic [3:0] ALUAND = 4'h2;
  localparam logic [3:0] ALUXOR = 4'h3;

  localparam logic [3:0] C_YES = 4'h0;
  localparam logic [3:0] C_LE  = 4'h1;
  localparam logic [3:0] C_L   = 4'h2;
  localparam logic [3:0] C_E   = 4'h3;
  localparam logic [3:0] C_NE  = 4'h4;
  localparam logic [3:0] C_GE  = 4'h5;
  localparam logic [3:0] C_G   = 4'h6;

  localparam logic [3:0] RSP   = 4'h4;
  localparam logic [3:0] RNONE = 4'hF;

  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } cc_t;

  localparam cc_t CC_RESET = cc_t'(3'b100);

  function automatic logic cond_met(input cc_t cc, input logic [3:0] fn);
    logic lt;
    lt = cc.sf ^ cc.of;
    case (fn)
      C_YES:   cond_met = 1'b1;
      C_LE:    cond_met = lt | cc.zf;
      C_L:     cond_met = lt;
      C_E:     cond_met = cc.zf;
      C_NE:    cond_met = ~cc.zf;
      C_GE:    cond_met = ~lt;
      C_G:     cond_met = ~lt & ~cc.zf;
      default: cond_met = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/y86_regfile.sv
// 15 x 64-bit register file: two combinational reads (id 0xF reads 0), two writes at the edge.
// Reads are zero-latency, writes land at the next rising edge; the M port wins a same-register clash.
module y86_regfile
  import y86_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  src_a,
  input  logic [3:0]  src_b,
  output logic [63:0] rd_a,
  output logic [63:0] rd_b,
  input  logic        we,
  input  logic [3:0]  dst_e,
  input  logic [63:0] val_e,
  input  logic [3:0]  dst_m,
  input  logic [63:0] val_m
);

  logic [63:0] regs [15];

  always_comb begin
    rd_a = (src_a == RNONE) ? '0 : regs[src_a];
    rd_b = (src_b == RNONE) ? '0 : regs[src_b];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 15; i++) regs[i] <= '0;
    end else if (we) begin
      for (int i = 0; i < 15; i++) begin
        if (dst_m == 4'(i))      regs[i] <= val_m;
        else if (dst_e == 4'(i)) regs[i] <= val_e;
      end
    end
  end

endmodule

// File: rtl/fetch_decode_execute.sv
// Y86-64 single-cycle fetch, decode and execute with register file and condition codes.
// All outputs are combinational from pc/instr/state; state commits at the next edge; no backpressure.
module fetch_decode_execute
  import y86_pkg::*;
#(
  parameter int IMEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] pc,
  input  logic [79:0] instr,
  input  logic [63:0] valM,
  output logic [3:0]  icode,
  output logic [3:0]  ifun,
  output logic [3:0]  rA,
  output logic [3:0]  rB,
  output logic [63:0] valC,
  output logic [63:0] valP,
  output logic [63:0] valA,
  output logic [63:0] valB,
  output logic [63:0] valE,
  output logic        cnd,
  output logic        instr_valid,
  output logic        imem_error
);

  logic [3:0]  ilen;
  logic        has_regs;
  logic [3:0]  src_a, src_b, dst_e, dst_m;
  logic [63:0] alu_a, alu_b;
  logic [3:0]  alu_fn;
  cc_t         cc_q, cc_d;
  logic        state_we;

  // Fetch: field split, length, constant word and encoding legality.
  always_comb begin
    icode    = instr[7:4];
    ifun     = instr[3:0];
    has_regs = icode inside {IRRMOVQ, IIRMOVQ, IRMMOVQ, IMRMOVQ, IOPQ, IPUSHQ, IPOPQ};
    rA       = has_regs ? instr[15:12] : RNONE;
    rB       = has_regs ? instr[11:8]  : RNONE;
    ilen     = 4'd1;
    valC     = '0;
    case (icode)
      IIRMOVQ, IRMMOVQ, IMRMOVQ: begin ilen = 4'd10; valC = instr[79:16]; end
      IJXX, ICALL:               begin ilen = 4'd9;  valC = instr[71:8];  end
      IRRMOVQ, IOPQ, IPUSHQ, IPOPQ: ilen = 4'd2;
      default:                   ilen = 4'd1;
    endcase
    valP = pc + {60'd0, ilen};
    case (icode)
      IRRMOVQ, IJXX: instr_valid = (ifun <= C_G);
      IOPQ:          instr_valid = (ifun <= ALUXOR);
      IHALT, INOP, IIRMOVQ, IRMMOVQ, IMRMOVQ, ICALL, IRET, IPUSHQ, IPOPQ:
                     instr_valid = (ifun == 4'h0);
      default:       instr_valid = 1'b0;
    endcase
  end

  // Widened so a pc near the top of the address space cannot wrap past the check.
  assign imem_error = ({1'b0, pc} + {61'd0, ilen}) > 65'(IMEM_BYTES);

  assign cnd = ((icode == IRRMOVQ) || (icode == IJXX)) && cond_met(cc_q, ifun);

  always_comb begin
    case (icode)
      IRRMOVQ, IRMMOVQ, IOPQ, IPUSHQ: src_a = rA;
      IRET, IPOPQ:                    src_a = RSP;
      default:                        src_a = RNONE;
    endcase
    case (icode)
      IRMMOVQ, IMRMOVQ, IOPQ:         src_b = rB;
      ICALL, IRET, IPUSHQ, IPOPQ:     src_b = RSP;
      default:                        src_b = RNONE;
    endcase
    case (icode)
      IIRMOVQ, IOPQ:                  dst_e = rB;
      IRRMOVQ:                        dst_e = cnd ? rB : RNONE;
      ICALL, IRET, IPUSHQ, IPOPQ:     dst_e = RSP;
      default:                        dst_e = RNONE;
    endcase
    dst_m = (icode == IMRMOVQ || icode == IPOPQ) ? rA : RNONE;
  end

  always_comb begin
    case (icode)
      IRRMOVQ, IOPQ:             alu_a = valA;
      IIRMOVQ, IRMMOVQ, IMRMOVQ: alu_a = valC;
      ICALL, IPUSHQ:             alu_a = 64'hFFFF_FFFF_FFFF_FFF8;
      IRET, IPOPQ:               alu_a = 64'd8;
      default:                   alu_a = '0;
    endcase
    case (icode)
      IRMMOVQ, IMRMOVQ, IOPQ, ICALL, IRET, IPUSHQ, IPOPQ: alu_b = valB;
      default:                                           alu_b = '0;
    endcase
    alu_fn = (icode == IOPQ) ? ifun : ALUADD;
    case (alu_fn)
      ALUSUB:  valE = alu_b - alu_a;
      ALUAND:  valE = alu_a & alu_b;
      ALUXOR:  valE = alu_a ^ alu_b;
      default: valE = alu_a + alu_b;
    endcase
    cc_d.zf = (valE == '0);
    cc_d.sf = valE[63];
    case (alu_fn)
      ALUADD:  cc_d.of = (alu_a[63] == alu_b[63]) && (valE[63] != alu_a[63]);
      ALUSUB:  cc_d.of = (alu_a[63] != alu_b[63]) && (valE[63] != alu_b[63]);
      default: cc_d.of = 1'b0;
    endcase
  end

  assign state_we = instr_valid && !imem_error && (icode != IHALT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           cc_q <= CC_RESET;
    else if (state_we && icode == IOPQ) cc_q <= cc_d;
  end

  y86_regfile u_regfile (
    .clk   (clk),
    .rst   (rst),
    .src_a (src_a),
    .src_b (src_b),
    .rd_a  (valA),
    .rd_b  (valB),
    .we    (state_we),
    .dst_e (dst_e),
    .val_e (valE),
    .dst_m (dst_m),
    .val_m (valM)
  );

endmodule

// File: tb/tb_fetch_decode_execute.sv
// Directed vector table, a reset corner sequence, then random instructions against an ISA-level model.
module tb_fetch_decode_execute;

  localparam int IMEM = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] pc;
  logic [79:0] instr;
  logic [63:0] valM;
  logic [3:0]  icode, ifun, rA, rB;
  logic [63:0] valC, valP, valA, valB, valE;
  logic        cnd, instr_valid, imem_error;

  fetch_decode_execute #(.IMEM_BYTES(IMEM)) dut (
    .clk(clk), .rst(rst), .pc(pc), .instr(instr), .valM(valM),
    .icode(icode), .ifun(ifun), .rA(rA), .rB(rB),
    .valC(valC), .valP(valP), .valA(valA), .valB(valB), .valE(valE),
    .cnd(cnd), .instr_valid(instr_valid), .imem_error(imem_error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Instruction encoders (byte 0 in the low byte).
  function automatic logic [79:0] f_irmov(input logic [3:0] rb, input logic [63:0] v);
    return {v, 4'hF, rb, 8'h30};
  endfunction
  function automatic logic [79:0] f_rr(input logic [7:0] b0, input logic [3:0] ra, input logic [3:0] rb);
    return {64'h0, ra, rb, b0};
  endfunction
  function automatic logic [79:0] f_mem(input logic [7:0] b0, input logic [3:0] ra, input logic [3:0] rb,
                                        input logic [63:0] d);
    return {d, ra, rb, b0};
  endfunction
  function automatic logic [79:0] f_jxx(input logic [7:0] b0, input logic [63:0] dest);
    return {8'h00, dest, b0};
  endfunction
  function automatic logic [79:0] f_one(input logic [7:0] b0);
    return {72'h0, b0};
  endfunction
  function automatic logic [79:0] f_probe(input logic [3:0] r);
    return f_mem(8'h40, r, 4'hF, 64'h0);
  endfunction

  typedef struct {
    logic [63:0] pc;
    logic [79:0] ins;
    logic [63:0] vm;
    logic        part;   // only icode and legality are defined
    logic        chk_e;  // valE is defined for this encoding
    logic [3:0]  e_ic, e_ra, e_rb;
    logic [63:0] e_vc, e_vp, e_va, e_vb, e_ve;
    logic        e_cnd, e_valid, e_err;
  } vec_t;

  function automatic vec_t mkv(input logic [63:0] p, input logic [79:0] ins, input logic [63:0] vm,
                               input logic part, input logic chk_e,
                               input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                               input logic [63:0] vc, input logic [63:0] vp, input logic [63:0] va,
                               input logic [63:0] vb, input logic [63:0] ve,
                               input logic c, input logic v, input logic e);
    vec_t r;
    r.pc = p; r.ins = ins; r.vm = vm; r.part = part; r.chk_e = chk_e;
    r.e_ic = ic; r.e_ra = ra; r.e_rb = rb; r.e_vc = vc; r.e_vp = vp;
    r.e_va = va; r.e_vb = vb; r.e_ve = ve; r.e_cnd = c; r.e_valid = v; r.e_err = e;
    return r;
  endfunction

  function automatic string nm(input int i, input string f);
    return $sformatf("vec%0d_%s", i, f);
  endfunction

  // ISA-level reference state.
  logic [63:0] m_reg [15];
  logic        m_zf, m_sf, m_of;

  function automatic logic [63:0] m_rd(input logic [3:0] r);
    return (r == 4'hF) ? 64'h0 : m_reg[r];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 15; i++) m_reg[i] = '0;
    m_zf = 1'b1; m_sf = 1'b0; m_of = 1'b0;
  endtask

  task automatic model_step(input int it);
    logic [3:0] ic, fn, ra, rb, sa, sb, de, dm;
    logic has_reg, v, er, c, lt, n_of;
    logic [63:0] vc, vp, va, vb, ve, opa, opb;
    logic signed [64:0] wide;
    int len;
    ic = instr[7:4]; fn = instr[3:0];
    case (ic)
      4'h0, 4'h1, 4'h9:       len = 1;
      4'h2, 4'h6, 4'hA, 4'hB: len = 2;
      4'h7, 4'h8:             len = 9;
      4'h3, 4'h4, 4'h5:       len = 10;
      default:                len = 1;
    endcase
    has_reg = ic inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB};
    ra = has_reg ? instr[15:12] : 4'hF;
    rb = has_reg ? instr[11:8]  : 4'hF;
    vc = (ic inside {4'h3, 4'h4, 4'h5}) ? instr[79:16] : (ic inside {4'h7, 4'h8}) ? instr[71:8] : 64'h0;
    vp = pc + 64'(len);
    er = (pc + 64'(len)) > 64'(IMEM);
    if (ic > 4'hB)                   v = 1'b0;
    else if (ic == 4'h6)             v = (fn <= 4'd3);
    else if (ic == 4'h2 || ic == 4'h7) v = (fn <= 4'd6);
    else                             v = (fn == 4'd0);
    sa = (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) ? ra : (ic inside {4'h9, 4'hB}) ? 4'h4 : 4'hF;
    sb = (ic inside {4'h4, 4'h5, 4'h6}) ? rb : (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) ? 4'h4 : 4'hF;
    va = m_rd(sa); vb = m_rd(sb);
    n_of = 1'b0;
    if (ic == 4'h6) begin
      case (fn)
        4'd1:    wide = $signed({vb[63], vb}) - $signed({va[63], va});
        4'd2:    wide = {1'b0, va & vb};
        4'd3:    wide = {1'b0, va ^ vb};
        default: wide = $signed({va[63], va}) + $signed({vb[63], vb});
      endcase
      ve = wide[63:0];
      n_of = (fn <= 4'd1) && (wide[64] != wide[63]);
    end else begin
      opa = (ic == 4'h2) ? va : (ic inside {4'h3, 4'h4, 4'h5}) ? vc :
            (ic inside {4'h8, 4'hA}) ? -64'd8 : (ic inside {4'h9, 4'hB}) ? 64'd8 : 64'd0;
      opb = (ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB}) ? vb : 64'd0;
      ve = opa + opb;
    end
    lt = m_sf ^ m_of;
    case (fn)
      4'd0: c = 1'b1;
      4'd1: c = lt | m_zf;
      4'd2: c = lt;
      4'd3: c = m_zf;
      4'd4: c = !m_zf;
      4'd5: c = !lt;
      4'd6: c = !lt && !m_zf;
      default: c = 1'b0;
    endcase
    if (!(ic == 4'h2 || ic == 4'h7)) c = 1'b0;

    chk($sformatf("rnd%0d_icode", it), 64'(icode), 64'(ic));
    chk($sformatf("rnd%0d_ifun", it), 64'(ifun), 64'(fn));
    chk($sformatf("rnd%0d_valid", it), 64'(instr_valid), 64'(v));
    chk($sformatf("rnd%0d_valA", it), valA, va);
    chk($sformatf("rnd%0d_valB", it), valB, vb);
    if (ic <= 4'hB) begin
      chk($sformatf("rnd%0d_rA", it), 64'(rA), 64'(ra));
      chk($sformatf("rnd%0d_rB", it), 64'(rB), 64'(rb));
      chk($sformatf("rnd%0d_valC", it), valC, vc);
      chk($sformatf("rnd%0d_valP", it), valP, vp);
      chk($sformatf("rnd%0d_err", it), 64'(imem_error), 64'(er));
    end
    if (v && !(ic inside {4'h0, 4'h1, 4'h7}))
      chk($sformatf("rnd%0d_valE", it), valE, ve);
    if (!((ic == 4'h2 || ic == 4'h7) && fn > 4'd6))
      chk($sformatf("rnd%0d_cnd", it), 64'(cnd), 64'(c));

    @(posedge clk); #1;
    if (v && !er && ic != 4'h0) begin
      if (ic == 4'h6) begin
        m_zf = (ve == 64'h0); m_sf = ve[63]; m_of = n_of;
      end
      de = (ic == 4'h3 || ic == 4'h6 || (ic == 4'h2 && c)) ? rb :
           (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) ? 4'h4 : 4'hF;
      dm = (ic == 4'h5 || ic == 4'hB) ? ra : 4'hF;
      if (de != 4'hF) m_reg[de] = ve;
      if (dm != 4'hF) m_reg[dm] = valM;
    end
  endtask

  vec_t vt[$];

  initial begin
    vt.push_back(mkv(64'h00,  f_jxx(8'h73, 64'h40), 0, 0, 0, 4'h7, 4'hF, 4'hF, 64'h40, 64'h09, 0, 0, 0, 1, 1, 0));
    vt.push_back(mkv(64'h00,  f_irmov(4'h0, 64'h10), 0, 0, 1, 4'h3, 4'hF, 4'h0, 64'h10, 64'h0A, 0, 0, 64'h10, 0, 1, 0));
    vt.push_back(mkv(64'h10,  f_mem(8'h40, 4'h0, 4'hF, 64'h8), 0, 0, 1, 4'h4, 4'h0, 4'hF, 64'h8, 64'h1A, 64'h10, 0, 64'h8, 0, 1, 0));
    vt.push_back(mkv(64'h1A,  f_irmov(4'h0, 64'h5), 0, 0, 1, 4'h3, 4'hF, 4'h0, 64'h5, 64'h24, 0, 0, 64'h5, 0, 1, 0));
    vt.push_back(mkv(64'h24,  f_irmov(4'h3, 64'h5), 0, 0, 1, 4'h3, 4'hF, 4'h3, 64'h5, 64'h2E, 0, 0, 64'h5, 0, 1, 0));
    vt.push_back(mkv(64'h2E,  f_rr(8'h60, 4'h0, 4'h3), 0, 0, 1, 4'h6, 4'h0, 4'h3, 0, 64'h30, 64'h5, 64'h5, 64'hA, 0, 1, 0));
    vt.push_back(mkv(64'h30,  f_jxx(8'h74, 64'h100), 0, 0, 0, 4'h7, 4'hF, 4'hF, 64'h100, 64'h39, 0, 0, 0, 1, 1, 0));
    vt.push_back(mkv(64'h39,  f_irmov(4'h3, 64'h5), 0, 0, 1, 4'h3, 4'hF, 4'h3, 64'h5, 64'h43, 0, 0, 64'h5, 0, 1, 0));
    vt.push_back(mkv(64'h43,  f_rr(8'h61, 4'h0, 4'h3), 0, 0, 1, 4'h6, 4'h0, 4'h3, 0, 64'h45, 64'h5, 64'h5, 64'h0, 0, 1, 0));
    vt.push_back(mkv(64'h45,  f_jxx(8'h74, 64'h100), 0, 0, 0, 4'h7, 4'hF, 4'hF, 64'h100, 64'h4E, 0, 0, 0, 0, 1, 0));
    vt.push_back(mkv(64'h4E,  f_jxx(8'h73, 64'h100), 0, 0, 0, 4'h7, 4'hF, 4'hF, 64'h100, 64'h57, 0, 0, 0, 1, 1, 0));
    vt.push_back(mkv(64'h57,  f_irmov(4'h4, 64'h100), 0, 0, 1, 4'h3, 4'hF, 4'h4, 64'h100, 64'h61, 0, 0, 64'h100, 0, 1, 0));
    vt.push_back(mkv(64'h61,  f_rr(8'hA0, 4'h0, 4'hF), 0, 0, 1, 4'hA, 4'h0, 4'hF, 0, 64'h63, 64'h5, 64'h100, 64'hF8, 0, 1, 0));
    vt.push_back(mkv(64'h63,  f_probe(4'h4), 0, 0, 1, 4'h4, 4'h4, 4'hF, 0, 64'h6D, 64'hF8, 0, 0, 0, 1, 0));
    vt.push_back(mkv(64'h6D,  f_rr(8'hB0, 4'h4, 4'hF), 64'h55, 0, 1, 4'hB, 4'h4, 4'hF, 0, 64'h6F, 64'hF8, 64'hF8, 64'h100, 0, 1, 0));
    vt.push_back(mkv(64'h6F,  f_probe(4'h4), 0, 0, 1, 4'h4, 4'h4, 4'hF, 0, 64'h79, 64'h55, 0, 0, 0, 1, 0));
    vt.push_back(mkv(64'h79,  f_one(8'hC0), 0, 1, 0, 4'hC, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vt.push_back(mkv(64'h7A,  f_rr(8'h64, 4'h0, 4'h3), 0, 1, 0, 4'h6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vt.push_back(mkv(64'h7C,  f_jxx(8'h73, 64'h100), 0, 0, 0, 4'h7, 4'hF, 4'hF, 64'h100, 64'h85, 0, 0, 0, 1, 1, 0));
    vt.push_back(mkv(64'h85,  f_probe(4'h3), 0, 0, 1, 4'h4, 4'h3, 4'hF, 0, 64'h8F, 64'h0, 0, 0, 0, 1, 0));
    vt.push_back(mkv(64'(IMEM - 5), f_irmov(4'h3, 64'h77), 0, 0, 1, 4'h3, 4'hF, 4'h3, 64'h77, 64'h405, 0, 0, 64'h77, 0, 1, 1));
    vt.push_back(mkv(64'h90,  f_probe(4'h3), 0, 0, 1, 4'h4, 4'h3, 4'hF, 0, 64'h9A, 64'h0, 0, 0, 0, 1, 0));
    vt.push_back(mkv(64'h9A,  f_one(8'h00), 0, 0, 0, 4'h0, 4'hF, 4'hF, 0, 64'h9B, 0, 0, 0, 0, 1, 0));
    vt.push_back(mkv(64'h9B,  f_probe(4'h3), 0, 0, 1, 4'h4, 4'h3, 4'hF, 0, 64'hA5, 64'h0, 0, 0, 0, 1, 0));
    vt.push_back(mkv(64'(IMEM - 10), f_irmov(4'h2, 64'h22), 0, 0, 1, 4'h3, 4'hF, 4'h2, 64'h22, 64'h400, 0, 0, 64'h22, 0, 1, 0));
    vt.push_back(mkv(64'h00,  f_probe(4'h2), 0, 0, 1, 4'h4, 4'h2, 4'hF, 0, 64'h0A, 64'h22, 0, 0, 0, 1, 0));

    rst = 1'b1; pc = '0; instr = '0; valM = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    foreach (vt[i]) begin
      pc = vt[i].pc; instr = vt[i].ins; valM = vt[i].vm;
      #2;
      chk(nm(i, "icode"), 64'(icode), 64'(vt[i].e_ic));
      chk(nm(i, "valid"), 64'(instr_valid), 64'(vt[i].e_valid));
      if (!vt[i].part) begin
        chk(nm(i, "rA"),   64'(rA), 64'(vt[i].e_ra));
        chk(nm(i, "rB"),   64'(rB), 64'(vt[i].e_rb));
        chk(nm(i, "valC"), valC, vt[i].e_vc);
        chk(nm(i, "valP"), valP, vt[i].e_vp);
        chk(nm(i, "valA"), valA, vt[i].e_va);
        chk(nm(i, "valB"), valB, vt[i].e_vb);
        chk(nm(i, "cnd"),  64'(cnd), 64'(vt[i].e_cnd));
        chk(nm(i, "err"),  64'(imem_error), 64'(vt[i].e_err));
        if (vt[i].chk_e) chk(nm(i, "valE"), valE, vt[i].e_ve);
      end
      @(posedge clk); #1;
    end

    // Reset between edges, then reset held across an edge with a writing instruction presented.
    pc = 64'h0; instr = f_irmov(4'h3, 64'h33);
    @(posedge clk); #1;
    instr = f_rr(8'h60, 4'h0, 4'h3);
    @(posedge clk); #1;
    instr = f_probe(4'h3); #1;
    chk("pre_rst_r3", valA, 64'h38);
    instr = f_jxx(8'h74, 64'h0); #1;
    chk("pre_rst_jne", 64'(cnd), 64'h1);
    @(negedge clk);
    rst = 1'b1; #1;
    chk("rst_cc_z", 64'(cnd), 64'h0);
    instr = f_probe(4'h3); #1;
    chk("rst_r3_async", valA, 64'h0);
    instr = f_irmov(4'h3, 64'h44);
    @(posedge clk); #1;
    rst = 1'b0; instr = f_probe(4'h3); #1;
    chk("rst_discard_r3", valA, 64'h0);
    @(posedge clk); #1;
    model_reset();

    for (int it = 0; it < 600; it++) begin
      logic [3:0] ic, fn;
      logic [79:0] ins;
      int sel;
      ic = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(12, 15)) : 4'($urandom_range(0, 11));
      if ($urandom_range(0, 5) == 0)       fn = 4'($urandom_range(0, 15));
      else if (ic == 4'h6)                 fn = 4'($urandom_range(0, 3));
      else if (ic == 4'h2 || ic == 4'h7)   fn = 4'($urandom_range(0, 6));
      else                                 fn = 4'h0;
      ins[31:0]  = $urandom;
      ins[63:32] = $urandom;
      ins[79:64] = 16'($urandom);
      sel = $urandom_range(0, 3);
      if (sel == 0)      ins[79:24] = '0;
      else if (sel == 1) ins[79:24] = '1;
      ins[7:0] = {ic, fn};
      instr = ins;
      pc    = ($urandom_range(0, 4) == 0) ? 64'(IMEM - $urandom_range(0, 12)) : 64'($urandom_range(0, 1000));
      valM  = {$urandom, $urandom};
      #2;
      model_step(it);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_decode_execute.md
FETCH_DECODE_EXECUTE -- requirements
Module: fetch_decode_execute

Interface
REQ-001 Parameter: IMEM_BYTES, 1024, instruction-memory size in bytes used for the fetch bounds check.
REQ-002 Port: clk  input  1  clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  reset; asynchronous, active-high.
REQ-004 Port: pc  input  64  address of the current instruction.
REQ-005 Port: instr  input  80  instruction bytes pc..pc+9; byte 0 in [7:0], little-endian.
REQ-006 Port: valM  input  64  data returned by the memory stage, written back to the register file.
REQ-007 Ports, all outputs: icode 4, ifun 4, rA 4, rB 4, valC 64, valP 64, valA 64, valB 64, valE 64, cnd 1, instr_valid 1, imem_error 1.

Function
REQ-008 Split fields: icode=byte0[7:4], ifun=byte0[3:0], rA=byte1[7:4], rB=byte1[3:0]; rA and rB read 0xF when the instruction has no register byte.
REQ-009 Length and valP=pc+length: 1 byte for icode 0, 1, 9; 2 bytes for 2, 6, A, B; 9 bytes for 7, 8; 10 bytes for 3, 4, 5.
REQ-010 valC: bytes 2..9 for icode 3, 4, 5; bytes 1..8 for icode 7, 8; 0 otherwise.
REQ-011 instr_valid=0 in any of these cases: icode>0xB; ifun≠0 for icode 0, 1, 3, 4, 5, 8, 9, A, B; ifun>3 for icode 6; ifun>6 for icode 2 or 7.
REQ-012 imem_error=1 when pc+length > IMEM_BYTES.
REQ-013 Register file: 15 x 64-bit registers, index 4 = RSP; reading index 0xF returns 0.
REQ-014 Decode sources: srcA = rA for icode 2, 4, 6, A; RSP for 9, B; else 0xF. srcB = rB for 4, 5, 6; RSP for 8, 9, A, B; else 0xF.
REQ-015 ALU A operand: valA for 2 and 6; valC for 3, 4, 5; -8 for 8 and A; +8 for 9 and B.
REQ-016 ALU B operand: valB for 4, 5, 6, 8, 9, A, B; 0 for 2 and 3.
REQ-017 ALU operation: for icode 6, ifun 0=add, 1=sub (B-A), 2=and, 3=xor; add for all other icodes; 64-bit wrap.
REQ-018 Condition codes: ZF, SF, OF, updated only at a clock edge executing a valid icode 6.
  - OF for add: operands share a sign and the result sign differs.
  - OF for sub: computed on B-A.
  - OF is 0 for and/xor.
REQ-019 cnd is combinational from the current CC:
  - ifun 0: 1
  - ifun 1 (le): (SF^OF)|ZF
  - ifun 2 (l): SF^OF
  - ifun 3 (e): ZF
  - ifun 4 (ne): !ZF
  - ifun 5 (ge): !(SF^OF)
  - ifun 6 (g): !(SF^OF)&!ZF
REQ-020 cnd is forced to 0 for icodes other than 2 and 7.
REQ-021 Writeback at the rising edge:
  - dstE = rB for 3 and 6, and for 2 when cnd=1; RSP for 8, 9, A, B. It receives valE.
  - dstM = rA for 5 and B. It receives valM.
  - When dstE and dstM are the same register, valM wins.
REQ-022 All state writes (register file and CC) are suppressed when instr_valid=0, imem_error=1, or icode=0 (halt).
REQ-023 Outputs are combinational from pc, instr and current state; one instruction per cycle; state updates at the next edge.

Reset
REQ-024 rst=1 asynchronously clears all registers to 0 and sets CC to ZF=1, SF=0, OF=0.
REQ-025 Writes are blocked while rst=1; the first update occurs at the first rising edge after deassertion.
REQ-026 Reset asserted mid-instruction discards that instruction's writeback.

Structure
REQ-027 Shared package y86_pkg: icode constants (IHALT..IPOPQ), ALU function codes, condition codes, RSP=4, RNONE=0xF.
REQ-028 One sub-module, y86_regfile: two combinational read ports, two synchronous write ports, async reset.
REQ-029 Fetch, decode and ALU/CC logic are inline in fetch_decode_execute.

Verification
REQ-030 irmovq: pc=0, instr=30 F0 10 00.. -> icode=3, rB=0, valC=0x10, valP=0xA, valE=0x10; after the edge r0=0x10.
REQ-031 subq %rax,%rbx with both registers equal to 5 -> valE=0, ZF=1 after the edge; then jne (74, ifun 4) -> cnd=0, valP=pc+9; je (73) -> cnd=1.
REQ-032 pushq %rax with RSP=0x100 -> valA=rax, valE=0xF8; after the edge RSP=0xF8. popq %rsp with valM=0x55 -> RSP=0x55 (M wins).
REQ-033 instr byte0=0xC0, or 0x64 -> instr_valid=0 and no register or CC change after the edge. pc=IMEM_BYTES-5 with irmovq -> imem_error=1 and no write.
REQ-034 Assert rst between edges after writing r3 -> r3 reads 0 immediately and CC=Z; halt (00) -> valP=pc+1 and no state change.
